branch_sequencer: RTL and testbench

- Executes a conditional branch instruction (brzr/brnz/brpl/brmi) over the shared single-bus datapath.
- Started by the main control unit with a one-cycle start pulse and the current IR.
- Drives the register-file, CON flip-flop, Y/ALU/Z and PC strobes to evaluate the condition on R[Ra] and, if the branch is taken, load PC <= PC + sign-extended C.
- Reports completion via done and keeps saturating taken/not-taken statistics.

---
 rtl/branch_sequencer_pkg.sv | 33 +++
 rtl/branch_sequencer_sat_counter.sv | 25 ++
 rtl/branch_sequencer.sv | 138 +++++++++++++
 tb/tb_branch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_sequencer_pkg
// Purpose : State encoding, opcode and IR field positions for branch_sequencer
// Revision: 1.0 - initial release
// ============================================================================
package branch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EVAL = 3'd1,
        ST_PCY  = 3'd2,
        ST_ADDC = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    localparam logic [4:0] C_BR_OPCODE = 5'b10010;

    localparam int C_OPC_MSB  = 31;
    localparam int C_OPC_LSB  = 27;
    localparam int C_RA_MSB   = 26;
    localparam int C_RA_LSB   = 23;
    localparam int C_COND_MSB = 20;
    localparam int C_COND_LSB = 19;
    localparam int C_C_MSB    = 18;

    localparam logic [1:0] C_COND_ZERO    = 2'b00;
    localparam logic [1:0] C_COND_NONZERO = 2'b01;
    localparam logic [1:0] C_COND_POS     = 2'b10;
    localparam logic [1:0] C_COND_NEG     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/branch_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones, asynchronous active-high clear
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : branch_sequencer
// Purpose : Control strobes for brzr/brnz/brpl/brmi over the single-bus datapath
// Revision: 1.0 - initial release
// ============================================================================
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE = C_BR_OPCODE,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             con_flag,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       cond_sel,
    output logic             gra,
    output logic             r_out,
    output logic             con_in,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic             alu_add,
    output logic             z_in,
    output logic             z_low_out,
    output logic             pc_in,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cond;
    logic       r_err;
    logic       w_is_br;
    logic       w_accept;
    logic       w_reject;
    logic       w_in_wb;

    // Ra and C are routed to the datapath directly; only the opcode and condition matter here
    logic w_unused_ir;
    assign w_unused_ir = ^{ir[C_RA_MSB:C_RA_LSB], ir[22:21], ir[C_C_MSB:0]};

    assign w_is_br  = (ir[C_OPC_MSB:C_OPC_LSB] == BR_OPCODE);
    assign w_accept = start && (r_state == ST_IDLE) &&  w_is_br;
    assign w_reject = start && (r_state == ST_IDLE) && !w_is_br;
    assign w_in_wb  = (r_state == ST_WB);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_cond  <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept) begin
                r_cond <= ir[C_COND_MSB:C_COND_LSB];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        gra       = 1'b0;
        r_out     = 1'b0;
        con_in    = 1'b0;
        pc_out    = 1'b0;
        y_in      = 1'b0;
        c_out     = 1'b0;
        alu_add   = 1'b0;
        z_in      = 1'b0;
        z_low_out = 1'b0;
        pc_in     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                gra    = 1'b1;
                r_out  = 1'b1;
                con_in = 1'b1;
                w_next = ST_PCY;
            end
            ST_PCY: begin
                pc_out = 1'b1;
                y_in   = 1'b1;
                w_next = ST_ADDC;
            end
            ST_ADDC: begin
                c_out   = 1'b1;
                alu_add = 1'b1;
                z_in    = 1'b1;
                w_next  = ST_WB;
            end
            ST_WB: begin
                // CON has had two edges to settle since con_in, so it is safe to use here
                z_low_out = 1'b1;
                pc_in     = con_flag;
                done      = 1'b1;
                w_next    = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    assign err      = r_err;
    assign cond_sel = r_cond;

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .clear (clear),
        .en    (w_in_wb && con_flag),
        .count (taken_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_not_taken_cnt (
        .clk   (clk),
        .clear (clear),
        .en    (w_in_wb && !con_flag),
        .count (not_taken_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_sequencer
// Purpose : Directed self-checking bench for branch_sequencer
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        con_flag = 1'b0;
    logic        busy, done, err;
    logic [1:0]  cond_sel;
    logic        gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, z_low_out, pc_in;
    logic [15:0] taken_cnt, not_taken_cnt;

    logic        s_start = 1'b0;
    logic [31:0] s_ir = 32'h0;
    logic        s_con_flag = 1'b0;
    logic        s_busy, s_done, s_err;
    logic [1:0]  s_cond_sel;
    logic        s_gra, s_r_out, s_con_in, s_pc_out, s_y_in, s_c_out, s_alu_add;
    logic        s_z_in, s_z_low_out, s_pc_in;
    logic [2:0]  s_taken_cnt, s_not_taken_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // {gra,r_out,con_in,pc_out,y_in,c_out,alu_add,z_in,z_low_out,pc_in,done,busy}
    logic [11:0] strb;
    assign strb = {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
                   z_low_out, pc_in, done, busy};

    localparam logic [11:0] P_IDLE   = 12'b0000_0000_0000;
    localparam logic [11:0] P_EVAL   = 12'b1110_0000_0001;
    localparam logic [11:0] P_PCY    = 12'b0001_1000_0001;
    localparam logic [11:0] P_ADDC   = 12'b0000_0111_0001;
    localparam logic [11:0] P_WB_T   = 12'b0000_0000_1111;
    localparam logic [11:0] P_WB_N   = 12'b0000_0000_1011;

    always #5 clk = ~clk;

    branch_sequencer u_dut (
        .clk(clk), .clear(clear), .start(start), .ir(ir), .con_flag(con_flag),
        .busy(busy), .done(done), .err(err), .cond_sel(cond_sel),
        .gra(gra), .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
        .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .z_low_out(z_low_out),
        .pc_in(pc_in), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
    );

    branch_sequencer #(.CNT_W(3)) u_dut_small (
        .clk(clk), .clear(clear), .start(s_start), .ir(s_ir), .con_flag(s_con_flag),
        .busy(s_busy), .done(s_done), .err(s_err), .cond_sel(s_cond_sel),
        .gra(s_gra), .r_out(s_r_out), .con_in(s_con_in), .pc_out(s_pc_out),
        .y_in(s_y_in), .c_out(s_c_out), .alu_add(s_alu_add), .z_in(s_z_in),
        .z_low_out(s_z_low_out), .pc_in(s_pc_in), .taken_cnt(s_taken_cnt),
        .not_taken_cnt(s_not_taken_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [1:0] cond);
        return {op, 4'd3, 2'b00, cond, 19'h00010};
    endfunction

    task automatic chk_strb(input string name, input logic [11:0] exp);
        n_cmp++;
        if (strb !== exp) begin
            n_bad++;
            $display("FAIL %s: strobes=%b expected=%b", name, strb, exp);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (3) tick();
        clear = 1'b0;
        tick();
        chk_strb("reset_strobes", P_IDLE);
        n_cmp++;
        if ({err, cond_sel, taken_cnt, not_taken_cnt} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_state: err=%b cond=%b tc=%0d ntc=%0d expected all 0",
                     err, cond_sel, taken_cnt, not_taken_cnt);
        end
    endtask

    task automatic test_taken_brzr();
        ir = mk_ir(5'b10010, 2'b00);
        con_flag = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_strb("brzr_eval", P_EVAL);
        tick();
        chk_strb("brzr_pcy", P_PCY);
        tick();
        chk_strb("brzr_addc", P_ADDC);
        tick();
        con_flag = 1'b1;
        #1;
        chk_strb("brzr_wb", P_WB_T);
        tick();
        con_flag = 1'b0;
        chk_strb("brzr_idle", P_IDLE);
        n_cmp++;
        if (taken_cnt !== 16'd1 || not_taken_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL brzr_cnt: tc=%0d ntc=%0d expected 1/0", taken_cnt, not_taken_cnt);
        end
    endtask

    task automatic test_not_taken_brmi();
        ir = mk_ir(5'b10010, 2'b11);
        con_flag = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (cond_sel !== 2'b11) begin
            n_bad++;
            $display("FAIL brmi_cond_sel: got=%b expected=11", cond_sel);
        end
        repeat (3) tick();
        chk_strb("brmi_wb", P_WB_N);
        tick();
        n_cmp++;
        if (taken_cnt !== 16'd1 || not_taken_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL brmi_cnt: tc=%0d ntc=%0d expected 1/1", taken_cnt, not_taken_cnt);
        end
    endtask

    task automatic test_illegal();
        ir = mk_ir(5'b00011, 2'b01);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_err_on: err=%b expected=1", err);
        end
        chk_strb("illegal_no_strobes", P_IDLE);
        tick();
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_err_off: err=%b busy=%b expected 0/0", err, busy);
        end
        n_cmp++;
        if (cond_sel !== 2'b11 || taken_cnt !== 16'd1 || not_taken_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL illegal_state: cond=%b tc=%0d ntc=%0d expected 11/1/1",
                     cond_sel, taken_cnt, not_taken_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        ir = mk_ir(5'b10010, 2'b01);
        con_flag = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (done) dones++;
        tick();
        ir = mk_ir(5'b10010, 2'b10);
        start = 1'b1;
        #1;
        if (done) dones++;
        tick();
        start = 1'b0;
        n_cmp++;
        if (cond_sel !== 2'b01 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_start_ignored: cond=%b err=%b expected 01/0", cond_sel, err);
        end
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            tick();
        end
        con_flag = 1'b0;
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL busy_single_done: done pulses=%0d expected=1", dones);
        end
        n_cmp++;
        if (taken_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL busy_cnt: tc=%0d expected=2", taken_cnt);
        end
    endtask

    task automatic test_back_to_back();
        ir = mk_ir(5'b10010, 2'b10);
        con_flag = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        ir = mk_ir(5'b10010, 2'b00);
        start = 1'b1;
        #1;
        chk_strb("b2b_wb", P_WB_N);
        tick();
        chk_strb("b2b_wb_start_ignored", P_IDLE);
        tick();
        start = 1'b0;
        chk_strb("b2b_reissue_eval", P_EVAL);
        n_cmp++;
        if (cond_sel !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_cond_sel: got=%b expected=00", cond_sel);
        end
        repeat (4) tick();
        n_cmp++;
        if (not_taken_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL b2b_cnt: ntc=%0d expected=3", not_taken_cnt);
        end
    endtask

    task automatic test_clear_mid();
        ir = mk_ir(5'b10010, 2'b01);
        con_flag = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk_strb("clr_addc", P_ADDC);
        clear = 1'b1;
        #1;
        chk_strb("clr_async", P_IDLE);
        tick();
        chk_strb("clr_next", P_IDLE);
        clear = 1'b0;
        repeat (4) tick();
        con_flag = 1'b0;
        n_cmp++;
        if (taken_cnt !== 16'd0 || busy !== 1'b0 || cond_sel !== 2'b00) begin
            n_bad++;
            $display("FAIL clr_state: tc=%0d busy=%b cond=%b expected 0/0/00",
                     taken_cnt, busy, cond_sel);
        end
    endtask

    task automatic test_saturation();
        s_ir = mk_ir(5'b10010, 2'b00);
        s_con_flag = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            repeat (4) tick();
            if (k == 7 || k == 8) begin
                n_cmp++;
                if (s_taken_cnt !== 3'd7) begin
                    n_bad++;
                    $display("FAIL sat_after_%0d: tc=%0d expected=7", k, s_taken_cnt);
                end
            end
        end
        n_cmp++;
        if (s_not_taken_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL sat_ntc: ntc=%0d expected=0", s_not_taken_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_taken_brzr();
        test_not_taken_brmi();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        test_clear_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
